// File: rtl/ws2812_pkg.sv
// Shared types and default constants for the multi-channel WS2812/SK6812 driver.
// Defaults target a 25 MHz clock driving 800 kHz strips.
package ws2812_pkg;

  // Per-channel serialiser state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  // Default bit timing in clk cycles at 25 MHz
  localparam int DEF_TBIT   = 31;
  localparam int DEF_T0H    = 10;
  localparam int DEF_T1H    = 20;
  localparam int DEF_TRESET = 1250;

  // Legal pixel widths: GRB (WS2812) and GRBW (SK6812)
  localparam int BPP_GRB  = 24;
  localparam int BPP_GRBW = 32;

endpackage

// File: rtl/ws2812_chan.sv
// One WS2812 output channel: pixel FIFO, bit-timing FSM and shift register.
// The FIFO is popped straight into the shifter, either from IDLE or at the
// end of the last bit of a pixel so consecutive pixels run without a gap.
module ws2812_chan
  import ws2812_pkg::*;
#(
  parameter int BPP    = BPP_GRB,
  parameter int DEPTH  = 8,
  parameter int TBIT   = DEF_TBIT,
  parameter int T0H    = DEF_T0H,
  parameter int T1H    = DEF_T1H,
  parameter int TRESET = DEF_TRESET
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           wr_en_i,
  input  logic [BPP-1:0] pixel_i,
  input  logic           invert_i,
  output logic           full_o,
  output logic           empty_o,
  output logic           busy_o,
  output logic           ovf_o,
  output logic           dout_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(TRESET);
  localparam int BW   = $clog2(BPP);

  // FIFO storage and bookkeeping
  logic [BPP-1:0]  mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;
  logic            full_q;
  logic            empty_q;
  logic            ovf_q;
  logic            push;
  logic            pop;
  logic [BPP-1:0]  rd_data;

  // Serialiser state
  state_e          state_q;
  logic [CW-1:0]   cyc_q;
  logic [BW-1:0]   bitcnt_q;
  logic [BPP-1:0]  shift_q;
  logic            dout_q;
  logic [CW-1:0]   hi_last;
  logic            frame_end;

  // Full is judged before any pop in the same cycle, so a write to a full
  // FIFO is always dropped even if a pixel leaves at that edge.
  assign push    = wr_en_i && !full_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Last cycle of the last bit of the current pixel
  assign frame_end = (state_q == ST_LOW) && (cyc_q == CW'(TBIT - 1)) && (bitcnt_q == '0);
  assign pop       = !empty_q && ((state_q == ST_IDLE) || frame_end);

  // Final cycle of the high phase depends on the bit being sent
  assign hi_last = shift_q[BPP-1] ? CW'(T1H - 1) : CW'(T0H - 1);

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pixel storage; no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pixel_i;
    end
  end

  // FIFO pointers and registered status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNTW'(DEPTH));
      empty_q <= (count_d == '0);
      if (wr_en_i && full_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Bit-timing FSM; cyc_q is shared by the high, low and latch phases and
  // dout is registered from the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      dout_q   <= invert_i;
    end else begin
      dout_q <= (state_q == ST_HIGH) ^ invert_i;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q  <= rd_data;
            bitcnt_q <= BW'(BPP - 1);
            cyc_q    <= '0;
            state_q  <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (cyc_q == hi_last) begin
            state_q <= ST_LOW;
          end
          cyc_q <= cyc_q + CW'(1);
        end
        ST_LOW: begin
          if (cyc_q == CW'(TBIT - 1)) begin
            cyc_q <= '0;
            if (bitcnt_q != '0) begin
              shift_q  <= shift_q << 1;
              bitcnt_q <= bitcnt_q - BW'(1);
              state_q  <= ST_HIGH;
            end else if (pop) begin
              shift_q  <= rd_data;
              bitcnt_q <= BW'(BPP - 1);
              state_q  <= ST_HIGH;
            end else begin
              state_q <= ST_LATCH;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        ST_LATCH: begin
          if (cyc_q == CW'(TRESET - 1)) begin
            cyc_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= '0;
        end
      endcase
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign ovf_o   = ovf_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign dout_o  = dout_q;

endmodule

// File: rtl/ws2812_multi.sv
// Multi-channel WS2812/SK6812 strip driver: decodes host writes onto
// CHANNELS independent serialisers and gathers their status and outputs.
// Optional feature macro WS2812_INVERT_EN adds a static per-channel
// 'invert' input that flips each serial output (including its idle level).
module ws2812_multi
  import ws2812_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int BPP      = BPP_GRB,
  parameter int DEPTH    = 8,
  parameter int TBIT     = DEF_TBIT,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int TRESET   = DEF_TRESET
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          wr_chan,
  input  logic [31:0]         wr_data,
`ifdef WS2812_INVERT_EN
  input  logic [CHANNELS-1:0] invert,
`endif
  output logic [CHANNELS-1:0] full,
  output logic [CHANNELS-1:0] empty,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] ovf,
  output logic [CHANNELS-1:0] dout
);

  logic [CHANNELS-1:0] invert_w;
  logic [BPP-1:0]      pixel;
  logic                unused_wr_data;

  // Pixels are left-aligned; low bits are ignored for 24-bit pixels
  assign pixel          = wr_data[31 -: BPP];
  assign unused_wr_data = ^wr_data;

`ifdef WS2812_INVERT_EN
  assign invert_w = invert;
`else
  assign invert_w = '0;
`endif

  // One serialiser per channel; channel numbers beyond CHANNELS match none
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic chan_wr;
    assign chan_wr = wr_en && (wr_chan == 3'(gi));

    ws2812_chan #(
      .BPP    (BPP),
      .DEPTH  (DEPTH),
      .TBIT   (TBIT),
      .T0H    (T0H),
      .T1H    (T1H),
      .TRESET (TRESET)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .wr_en_i  (chan_wr),
      .pixel_i  (pixel),
      .invert_i (invert_w[gi]),
      .full_o   (full[gi]),
      .empty_o  (empty[gi]),
      .busy_o   (busy[gi]),
      .ovf_o    (ovf[gi]),
      .dout_o   (dout[gi])
    );
  end

endmodule

// File: tb/tb_ws2812_multi.sv
// Bench for ws2812_multi: records every output each cycle, then compares the
// serial waveforms against an ideal waveform built from pixel values and the
// bit-timing rules, 31 cycles at a time.
module tb_ws2812_multi;

  localparam int TBIT   = 31;
  localparam int T0H    = 10;
  localparam int T1H    = 20;
  localparam int TRESET = 1250;
  localparam int PIX24  = 24 * TBIT;
  localparam int NE     = 65536;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [31:0] wr_data;
  logic [3:0]  full, empty, busy, ovf, dout;
  logic        wr_en32;
  logic [2:0]  wr_chan32;
  logic [31:0] wr_data32;
  logic [0:0]  full32, empty32, busy32, ovf32, dout32;
  logic [3:0]  inv;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [3:0] tr_dout  [NE];
  logic [3:0] tr_busy  [NE];
  logic [3:0] tr_empty [NE];
  logic [3:0] tr_full  [NE];
  logic [3:0] tr_ovf   [NE];
  logic       tr_d32   [NE];
  logic       tr_b32   [NE];

  logic exp_w[$];

`ifdef WS2812_INVERT_EN
  assign inv = 4'b0001;
`else
  assign inv = 4'b0000;
`endif

  always #5 clk = ~clk;

  ws2812_multi #(.CHANNELS(4), .BPP(24), .DEPTH(8), .TBIT(TBIT), .T0H(T0H),
                 .T1H(T1H), .TRESET(TRESET)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
`ifdef WS2812_INVERT_EN
    .invert(inv),
`endif
    .full(full), .empty(empty), .busy(busy), .ovf(ovf), .dout(dout)
  );

  ws2812_multi #(.CHANNELS(1), .BPP(32), .DEPTH(8), .TBIT(TBIT), .T0H(T0H),
                 .T1H(T1H), .TRESET(TRESET)) dut32 (
    .clk(clk), .reset(reset), .wr_en(wr_en32), .wr_chan(wr_chan32), .wr_data(wr_data32),
`ifdef WS2812_INVERT_EN
    .invert(inv[0:0]),
`endif
    .full(full32), .empty(empty32), .busy(busy32), .ovf(ovf32), .dout(dout32)
  );

  // edge_n = index of the most recent rising edge; traces hold values after it
  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (edge_n < NE) begin
      tr_dout[edge_n]  <= dout;
      tr_busy[edge_n]  <= busy;
      tr_empty[edge_n] <= empty;
      tr_full[edge_n]  <= full;
      tr_ovf[edge_n]   <= ovf;
      tr_d32[edge_n]   <= dout32[0];
      tr_b32[edge_n]   <= busy32[0];
    end
  end

  // ---------------- reference waveform model ----------------
  task automatic add_low(input int n);
    repeat (n) exp_w.push_back(1'b0);
  endtask

  // Each bit: TBIT cycles, high for T1H (1-bit) or T0H (0-bit), MSB first
  task automatic add_pixel(input logic [31:0] px, input int bpp);
    for (int b = 31; b >= 32 - bpp; b--) begin
      int h;
      h = px[b] ? T1H : T0H;
      for (int c = 0; c < TBIT; c++) exp_w.push_back(c < h);
    end
  endtask

  function automatic int nchunks();
    return (exp_w.size() + TBIT - 1) / TBIT;
  endfunction

  function automatic logic [31:0] exp_chunk(input int k, input logic iv);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < TBIT; i++)
      if (k * TBIT + i < exp_w.size()) r[i] = exp_w[k * TBIT + i] ^ iv;
    return r;
  endfunction

  // ch 8 selects the 32-bit instance
  function automatic logic [31:0] obs_chunk(input int ch, input int base, input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < TBIT; i++)
      if (k * TBIT + i < exp_w.size())
        r[i] = (ch == 8) ? tr_d32[base + k * TBIT + i] : tr_dout[base + k * TBIT + i][ch];
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] ch, input logic [31:0] d, output int e);
    wr_en = 1'b1; wr_chan = ch; wr_data = d;
    @(posedge clk); #1;
    e = edge_n;
    wr_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] zero4;
    zero4 = '0;
    reset = 1'b0;
    tick(3);
    checks++; if (dout !== inv) begin errors++; $display("FAIL reset_dout got %b want %b", dout, inv); end
    checks++; if (empty !== 4'hf) begin errors++; $display("FAIL reset_empty got %b want 1111", empty); end
    checks++; if (full !== zero4) begin errors++; $display("FAIL reset_full got %b want 0000", full); end
    checks++; if (busy !== zero4) begin errors++; $display("FAIL reset_busy got %b want 0000", busy); end
    checks++; if (ovf !== zero4) begin errors++; $display("FAIL reset_ovf got %b want 0000", ovf); end
    checks++; if ({empty32, full32, busy32, ovf32, dout32} !== {1'b1, 3'b000, inv[0]})
      begin errors++; $display("FAIL reset_dut32 got %b want %b", {empty32, full32, busy32, ovf32, dout32}, {1'b1, 3'b000, inv[0]}); end
    reset = 1'b1;
    tick(2);
    checks++; if ({busy, dout} !== {4'h0, inv}) begin errors++; $display("FAIL post_reset_idle got %b want %b", {busy, dout}, {4'h0, inv}); end
  endtask

  task automatic test_single();
    int n, base, last;
    logic [2:0] dev;
    push(3'd0, 32'hff00ff00, n);
    tick(PIX24 + TRESET + 60);
    checks++; if (tr_empty[n-1][0] !== 1'b1) begin errors++; $display("FAIL single_empty_before got %b want 1", tr_empty[n-1][0]); end
    checks++; if (tr_empty[n][0] !== 1'b0) begin errors++; $display("FAIL single_empty_after_wr got %b want 0", tr_empty[n][0]); end
    checks++; if (tr_empty[n+1][0] !== 1'b1) begin errors++; $display("FAIL single_empty_after_pop got %b want 1", tr_empty[n+1][0]); end
    checks++; if ({tr_busy[n][0], tr_busy[n+1][0]} !== 2'b01) begin errors++; $display("FAIL single_busy_rise got %b want 01", {tr_busy[n][0], tr_busy[n+1][0]}); end
    last = n + PIX24 + TRESET;
    checks++; if ({tr_busy[last][0], tr_busy[last+1][0]} !== 2'b10) begin errors++; $display("FAIL single_busy_fall got %b want 10", {tr_busy[last][0], tr_busy[last+1][0]}); end
    exp_w.delete();
    add_low(1); add_pixel(32'hff00ff00, 24); add_low(TRESET);
    base = n + 1;
    for (int k = 0; k < nchunks(); k++) begin
      checks++;
      if (obs_chunk(0, base, k) !== exp_chunk(k, inv[0])) begin
        errors++; $display("FAIL single_wave chunk %0d got %h want %h", k, obs_chunk(0, base, k), exp_chunk(k, inv[0]));
      end
    end
    dev = '0;
    for (int i = n; i < last + 2; i++) dev = dev | (tr_dout[i][3:1] ^ inv[3:1]);
    checks++; if (dev !== 3'b000) begin errors++; $display("FAIL single_others_quiet got %b want 000", dev); end
  endtask

  task automatic test_back_to_back();
    int n, n2, base, last;
    push(3'd1, 32'h80000000, n);
    push(3'd1, 32'h00000000, n2);
    tick(2 * PIX24 + TRESET + 60);
    checks++; if (tr_empty[n2][1] !== 1'b0) begin errors++; $display("FAIL b2b_occupancy got empty %b want 0", tr_empty[n2][1]); end
    checks++; if ({tr_empty[n+PIX24][1], tr_empty[n+PIX24+1][1]} !== 2'b01) begin errors++; $display("FAIL b2b_second_pop got %b want 01", {tr_empty[n+PIX24][1], tr_empty[n+PIX24+1][1]}); end
    last = n + 2 * PIX24 + TRESET;
    checks++; if ({tr_busy[last][1], tr_busy[last+1][1]} !== 2'b10) begin errors++; $display("FAIL b2b_busy_fall got %b want 10", {tr_busy[last][1], tr_busy[last+1][1]}); end
    exp_w.delete();
    add_low(1); add_pixel(32'h80000000, 24); add_pixel(32'h00000000, 24); add_low(TRESET);
    base = n + 1;
    for (int k = 0; k < nchunks(); k++) begin
      checks++;
      if (obs_chunk(1, base, k) !== exp_chunk(k, inv[1])) begin
        errors++; $display("FAIL b2b_wave chunk %0d got %h want %h", k, obs_chunk(1, base, k), exp_chunk(k, inv[1]));
      end
    end
  endtask

  task automatic test_overflow();
    int n0, base, idle_e;
    int w[9];
    logic [31:0] a;
    logic [31:0] px[9];
    a = $urandom;
    for (int i = 0; i < 9; i++) px[i] = $urandom;
    push(3'd2, a, n0);
    tick(798);
    // nine writes land while the channel sits in its latch gap
    for (int i = 0; i < 9; i++) push(3'd2, px[i], w[i]);
    tick(8500);
    checks++; if ({tr_full[w[6]][2], tr_full[w[7]][2]} !== 2'b01) begin errors++; $display("FAIL ovf_full_after_8th got %b want 01", {tr_full[w[6]][2], tr_full[w[7]][2]}); end
    checks++; if ({tr_ovf[w[7]][2], tr_ovf[w[8]][2]} !== 2'b01) begin errors++; $display("FAIL ovf_flag_after_9th got %b want 01", {tr_ovf[w[7]][2], tr_ovf[w[8]][2]}); end
    idle_e = n0 + 1 + PIX24 + TRESET;
    checks++; if ({tr_busy[idle_e-1][2], tr_busy[idle_e][2]} !== 2'b10) begin errors++; $display("FAIL ovf_gap_not_shortened got %b want 10", {tr_busy[idle_e-1][2], tr_busy[idle_e][2]}); end
    checks++; if ({tr_full[idle_e][2], tr_full[idle_e+1][2]} !== 2'b10) begin errors++; $display("FAIL ovf_full_clears got %b want 10", {tr_full[idle_e][2], tr_full[idle_e+1][2]}); end
    checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_sticky got %b want 0100", ovf); end
    exp_w.delete();
    add_low(1); add_pixel(a, 24); add_low(TRESET + 1);
    for (int i = 0; i < 8; i++) add_pixel(px[i], 24);
    add_low(TRESET);
    base = n0 + 1;
    for (int k = 0; k < nchunks(); k++) begin
      checks++;
      if (obs_chunk(2, base, k) !== exp_chunk(k, inv[2])) begin
        errors++; $display("FAIL ovf_wave chunk %0d got %h want %h", k, obs_chunk(2, base, k), exp_chunk(k, inv[2]));
      end
    end
  endtask

  task automatic test_bpp32();
    int n, base, last;
    wr_en32 = 1'b1; wr_chan32 = 3'd0; wr_data32 = 32'h000000ff;
    @(posedge clk); #1;
    n = edge_n;
    wr_en32 = 1'b0;
    tick(32 * TBIT + TRESET + 60);
    last = n + 32 * TBIT + TRESET;
    checks++; if ({tr_b32[last], tr_b32[last+1]} !== 2'b10) begin errors++; $display("FAIL bpp32_busy_fall got %b want 10", {tr_b32[last], tr_b32[last+1]}); end
    exp_w.delete();
    add_low(1); add_pixel(32'h000000ff, 32); add_low(TRESET);
    base = n + 1;
    for (int k = 0; k < nchunks(); k++) begin
      checks++;
      if (obs_chunk(8, base, k) !== exp_chunk(k, inv[0])) begin
        errors++; $display("FAIL bpp32_wave chunk %0d got %h want %h", k, obs_chunk(8, base, k), exp_chunk(k, inv[0]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, n2, r, n3, base;
    logic [31:0] p1, p2, p3;
    p1 = $urandom; p2 = $urandom; p3 = $urandom;
    push(3'd0, p1, n);
    push(3'd0, p2, n2);
    tick(170);
    reset = 1'b0;
    @(posedge clk); #1;
    r = edge_n;
    reset = 1'b1;
    push(3'd0, p3, n3);
    tick(PIX24 + TRESET + 60);
    exp_w.delete();
    add_low(1); add_pixel(p1, 24);
    checks++; if (tr_dout[r-1][0] !== (exp_w[r-1-(n+1)] ^ inv[0])) begin errors++; $display("FAIL rstmid_before got %b want %b", tr_dout[r-1][0], exp_w[r-1-(n+1)] ^ inv[0]); end
    checks++; if (tr_dout[r][0] !== inv[0]) begin errors++; $display("FAIL rstmid_dout got %b want %b", tr_dout[r][0], inv[0]); end
    checks++; if ({tr_empty[r], tr_busy[r], tr_full[r], tr_ovf[r]} !== 16'hf000)
      begin errors++; $display("FAIL rstmid_flags got %h want f000", {tr_empty[r], tr_busy[r], tr_full[r], tr_ovf[r]}); end
    exp_w.delete();
    add_low(1); add_pixel(p3, 24); add_low(TRESET);
    base = n3 + 1;
    for (int k = 0; k < nchunks(); k++) begin
      checks++;
      if (obs_chunk(0, base, k) !== exp_chunk(k, inv[0])) begin
        errors++; $display("FAIL rstmid_restart chunk %0d got %h want %h", k, obs_chunk(0, base, k), exp_chunk(k, inv[0]));
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int ca, cb, na, nb, e0, ea, eb, e, base;
      logic [31:0] pa[$];
      logic [31:0] pb[$];
      ca = $urandom_range(0, 3);
      cb = (ca + 1 + $urandom_range(0, 2)) % 4;
      na = $urandom_range(1, 3);
      nb = $urandom_range(1, 3);
      ea = 0; eb = 0;
      push(3'(4 + $urandom_range(0, 3)), $urandom, e0);
      for (int i = 0; i < 3; i++) begin
        if (i < na) begin pa.push_back($urandom); push(3'(ca), pa[i], e); if (i == 0) ea = e; end
        if (i < nb) begin pb.push_back($urandom); push(3'(cb), pb[i], e); if (i == 0) eb = e; end
      end
      tick(3 * PIX24 + TRESET + 100);
      checks++; if ({busy, empty} !== 8'h0f) begin errors++; $display("FAIL rand%0d_final_idle got %h want 0f", it, {busy, empty}); end
      for (int ch = 0; ch < 4; ch++) begin
        exp_w.delete();
        if (ch == ca) begin
          base = ea + 1; add_low(1);
          foreach (pa[i]) add_pixel(pa[i], 24);
          add_low(TRESET);
        end else if (ch == cb) begin
          base = eb + 1; add_low(1);
          foreach (pb[i]) add_pixel(pb[i], 24);
          add_low(TRESET);
        end else begin
          base = e0; add_low(1 + 3 * PIX24 + TRESET);
        end
        for (int k = 0; k < nchunks(); k++) begin
          checks++;
          if (obs_chunk(ch, base, k) !== exp_chunk(k, inv[ch])) begin
            errors++; $display("FAIL rand%0d_wave ch%0d chunk %0d got %h want %h", it, ch, k, obs_chunk(ch, base, k), exp_chunk(k, inv[ch]));
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_data = '0;
    wr_en32 = 1'b0; wr_chan32 = '0; wr_data32 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_bpp32();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
